// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types and constants for the parametrised combination lock.
//   state_t            : lock FSM state encoding (LOCKED / UNLOCKED / LOCKOUT)
//   DEFAULT_RESET_CODE : factory code for the default 6 x 4-bit build;
//                        digit 0 sits in the LSBs and is entered first,
//                        giving the entry sequence 3,3,5,2,5,6.
package code_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  localparam logic [23:0] DEFAULT_RESET_CODE = {4'd6, 4'd5, 4'd2, 4'd5, 4'd3, 4'd3};

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter with a zero flag.
// The lockout period and the optional auto-relock idle window are timed by
// the same instance, because only one of them can be running in any state.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (count clears to 0)
//   i_load     in   load i_load_val (takes priority over decrement)
//   i_load_val in   W-bit value to load
//   i_dec      in   decrement by one; holds at zero
//   o_zero     out  count is zero
module lock_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/code_lock.sv
// code_lock: parametrised combination lock with a code register, full-sequence
// evaluation (no early abort on a wrong digit), failed-attempt counting and a
// timed lockout.
// Optional feature macro: CODE_LOCK_AUTO_RELOCK_EN -- when defined, the lock
// returns to LOCKED after AUTO_RELOCK_CYCLES idle cycles in UNLOCKED.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   digit_valid  in   digit strobe, one digit consumed per cycle
//   digit        in   DIGIT_W keypad digit
//   code_wr      in   load code_in into the code register (UNLOCKED only)
//   code_in      in   CODE_LEN*DIGIT_W new code, digit 0 in LSBs
//   relock       in   return to LOCKED (UNLOCKED only)
//   locked       out  low only in UNLOCKED
//   lockout      out  high only in LOCKOUT
//   unlock_pulse out  one-cycle pulse on entry to UNLOCKED
//   fail_pulse   out  one-cycle pulse on each failed attempt
module code_lock
  import code_lock_pkg::*;
#(
  parameter int unsigned                     DIGIT_W            = 4,
  parameter int unsigned                     CODE_LEN           = 6,
  parameter logic [CODE_LEN*DIGIT_W-1:0]     RESET_CODE         = DEFAULT_RESET_CODE,
  parameter int unsigned                     MAX_FAILS          = 3,
  parameter int unsigned                     LOCKOUT_CYCLES     = 16,
  parameter int unsigned                     AUTO_RELOCK_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         digit_valid,
  input  logic [DIGIT_W-1:0]           digit,
  input  logic                         code_wr,
  input  logic [CODE_LEN*DIGIT_W-1:0]  code_in,
  input  logic                         relock,
  output logic                         locked,
  output logic                         lockout,
  output logic                         unlock_pulse,
  output logic                         fail_pulse
);

  localparam int unsigned IDX_W   = $clog2(CODE_LEN);
  localparam int unsigned FC_W    = $clog2(MAX_FAILS + 1);
  // Timer is sized for whichever period is longer so one counter serves both.
  localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > AUTO_RELOCK_CYCLES) ?
                                    LOCKOUT_CYCLES : AUTO_RELOCK_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]  FAIL_LAST    = FC_W'(MAX_FAILS - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef CODE_LOCK_AUTO_RELOCK_EN
  localparam logic [TMR_W-1:0] RELOCK_LOAD  = TMR_W'(AUTO_RELOCK_CYCLES - 1);
`endif

  state_t                        r_state, w_state_nxt;
  logic [IDX_W-1:0]              r_idx, w_idx_nxt;
  logic                          r_mismatch, w_mismatch_nxt;
  logic [FC_W-1:0]               r_fail_cnt, w_fail_cnt_nxt;
  logic [CODE_LEN*DIGIT_W-1:0]   r_code;
  logic                          r_locked, r_lockout, r_unlock_pulse, r_fail_pulse;

  logic                          w_code_we;
  logic                          w_unlock_set, w_fail_set;
  logic                          w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [TMR_W-1:0]              w_tmr_load_val;
  logic                          w_digit_ne, w_attempt_bad;

  lock_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  assign w_digit_ne    = (digit != r_code[r_idx*DIGIT_W +: DIGIT_W]);
  // The final digit's own compare is folded in before the verdict.
  assign w_attempt_bad = r_mismatch | w_digit_ne;

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mismatch_nxt = r_mismatch;
    w_fail_cnt_nxt = r_fail_cnt;
    w_code_we      = 1'b0;
    w_unlock_set   = 1'b0;
    w_fail_set     = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_dec      = 1'b0;

    unique case (r_state)
      LOCKED: begin
        if (digit_valid) begin
          if (r_idx == IDX_LAST) begin
            w_idx_nxt      = '0;
            w_mismatch_nxt = 1'b0;
            if (!w_attempt_bad) begin
              w_state_nxt    = UNLOCKED;
              w_unlock_set   = 1'b1;
              w_fail_cnt_nxt = '0;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
              w_tmr_load     = 1'b1;
              w_tmr_load_val = RELOCK_LOAD;
`endif
            end else begin
              w_fail_set = 1'b1;
              // Counter never passes MAX_FAILS-1: the reaching attempt
              // clears it on the way into lockout.
              if (r_fail_cnt >= FAIL_LAST) begin
                w_state_nxt    = LOCKOUT;
                w_fail_cnt_nxt = '0;
                w_tmr_load     = 1'b1;
                w_tmr_load_val = LOCKOUT_LOAD;
              end else begin
                w_fail_cnt_nxt = r_fail_cnt + 1'b1;
              end
            end
          end else begin
            w_idx_nxt      = r_idx + 1'b1;
            w_mismatch_nxt = w_attempt_bad;
          end
        end
      end

      UNLOCKED: begin
        w_code_we = code_wr;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
        if (relock) begin
          w_state_nxt = LOCKED;
          w_idx_nxt   = '0;
        end else if (code_wr || digit_valid) begin
          w_tmr_load     = 1'b1;
          w_tmr_load_val = RELOCK_LOAD;
        end else if (w_tmr_zero) begin
          w_state_nxt = LOCKED;
          w_idx_nxt   = '0;
        end else begin
          w_tmr_dec = 1'b1;
        end
`else
        if (relock) begin
          w_state_nxt = LOCKED;
          w_idx_nxt   = '0;
        end
`endif
      end

      LOCKOUT: begin
        if (w_tmr_zero) begin
          w_state_nxt = LOCKED;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      default: begin
        w_state_nxt = LOCKED;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= LOCKED;
      r_idx          <= '0;
      r_mismatch     <= 1'b0;
      r_fail_cnt     <= '0;
      r_code         <= RESET_CODE;
      r_locked       <= 1'b1;
      r_lockout      <= 1'b0;
      r_unlock_pulse <= 1'b0;
      r_fail_pulse   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_mismatch     <= w_mismatch_nxt;
      r_fail_cnt     <= w_fail_cnt_nxt;
      if (w_code_we) begin
        r_code <= code_in;
      end
      // Outputs are registered from the next state so they line up with r_state.
      r_locked       <= (w_state_nxt != UNLOCKED);
      r_lockout      <= (w_state_nxt == LOCKOUT);
      r_unlock_pulse <= w_unlock_set;
      r_fail_pulse   <= w_fail_set;
    end
  end

  assign locked       = r_locked;
  assign lockout      = r_lockout;
  assign unlock_pulse = r_unlock_pulse;
  assign fail_pulse   = r_fail_pulse;

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: directed scenarios followed by randomized traffic, with every
// output compared each cycle against a behavioural model that collects whole
// attempts in a queue and judges them against the stored code digits.
module tb_code_lock;

  localparam int unsigned DW = 4;
  localparam int unsigned CL = 6;
  localparam int unsigned MF = 3;
  localparam int unsigned LC = 16;
  localparam int unsigned AR = 64;
  localparam logic [CL*DW-1:0] TB_RESET_CODE = {4'd6, 4'd5, 4'd2, 4'd5, 4'd3, 4'd3};
  localparam logic [CL*DW-1:0] CODE_123456   = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [CL*DW-1:0] WRONG_CODE    = {4'd6, 4'd5, 4'd2, 4'd5, 4'd9, 4'd3};

  localparam int M_LOCKED   = 0;
  localparam int M_UNLOCKED = 1;
  localparam int M_LOCKOUT  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             digit_valid;
  logic [DW-1:0]    digit;
  logic             code_wr;
  logic [CL*DW-1:0] code_in;
  logic             relock;
  logic             locked, lockout, unlock_pulse, fail_pulse;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int   m_mode;
  int   m_entry[$];
  int   m_code[CL];
  int   m_fails;
  int   m_left;
  int   m_idle;
  logic e_locked, e_lockout, e_unlock, e_fail;

  code_lock #(
    .DIGIT_W            (DW),
    .CODE_LEN           (CL),
    .RESET_CODE         (TB_RESET_CODE),
    .MAX_FAILS          (MF),
    .LOCKOUT_CYCLES     (LC),
    .AUTO_RELOCK_CYCLES (AR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .code_wr      (code_wr),
    .code_in      (code_in),
    .relock       (relock),
    .locked       (locked),
    .lockout      (lockout),
    .unlock_pulse (unlock_pulse),
    .fail_pulse   (fail_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_code(input logic [CL*DW-1:0] c);
    for (int i = 0; i < CL; i++) m_code[i] = int'(c[i*DW +: DW]);
  endtask

  task automatic model_step(input logic rst, input logic dv, input logic [DW-1:0] d,
                            input logic cw, input logic [CL*DW-1:0] ci, input logic rl);
    bit ok;
    e_unlock = 1'b0;
    e_fail   = 1'b0;
    if (rst) begin
      m_mode  = M_LOCKED;
      m_entry.delete();
      m_fails = 0;
      m_left  = 0;
      m_idle  = 0;
      load_code(TB_RESET_CODE);
    end else begin
      case (m_mode)
        M_LOCKED: begin
          if (dv) begin
            m_entry.push_back(int'(d));
            if (m_entry.size() == CL) begin
              ok = 1'b1;
              for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
              m_entry.delete();
              if (ok) begin
                m_mode   = M_UNLOCKED;
                m_fails  = 0;
                m_idle   = AR;
                e_unlock = 1'b1;
              end else begin
                e_fail = 1'b1;
                m_fails++;
                if (m_fails >= MF) begin
                  m_mode  = M_LOCKOUT;
                  m_left  = LC;
                  m_fails = 0;
                end
              end
            end
          end
        end
        M_UNLOCKED: begin
          if (cw) load_code(ci);
          if (rl) m_mode = M_LOCKED;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
          else if (cw || dv) m_idle = AR;
          else begin
            m_idle--;
            if (m_idle == 0) m_mode = M_LOCKED;
          end
`endif
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = M_LOCKED;
        end
      endcase
    end
    e_locked  = (m_mode != M_UNLOCKED);
    e_lockout = (m_mode == M_LOCKOUT);
  endtask

  task automatic cyc(input logic dv, input logic [DW-1:0] d, input logic cw,
                     input logic [CL*DW-1:0] ci, input logic rl, input logic rst);
    reset       = rst;
    digit_valid = dv;
    digit       = d;
    code_wr     = cw;
    code_in     = ci;
    relock      = rl;
    @(posedge clk);
    model_step(rst, dv, d, cw, ci, rl);
    #1;
    chk("locked", 32'(locked), 32'(e_locked));
    chk("lockout", 32'(lockout), 32'(e_lockout));
    chk("unlock_pulse", 32'(unlock_pulse), 32'(e_unlock));
    chk("fail_pulse", 32'(fail_pulse), 32'(e_fail));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic enter(input logic [CL*DW-1:0] c);
    for (int i = 0; i < CL; i++) cyc(1'b1, c[i*DW +: DW], 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_relock();
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  int               q[$];
  logic             r_dv, r_cw, r_rl, r_rst;
  logic [DW-1:0]    r_d;
  logic [CL*DW-1:0] r_ci;

  initial begin
    // Reset and power-on state
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("reset_locked", 32'(locked), 32'd1);

    // Correct factory code
    enter(TB_RESET_CODE);
    chk("unlock_after_6th", 32'(locked), 32'd0);
    idle(3);
    do_relock();

    // One wrong digit, then the correct code
    enter(WRONG_CODE);
    chk("wrong_stays_locked", 32'(locked), 32'd1);
    idle(2);
    enter(TB_RESET_CODE);
    do_relock();

    // Three failures -> lockout; correct code ignored during lockout
    for (int a = 0; a < 3; a++) enter(WRONG_CODE);
    chk("lockout_entered", 32'(lockout), 32'd1);
    enter(TB_RESET_CODE);
    chk("lockout_ignores_code", 32'(locked), 32'd1);
    idle(12);
    enter(TB_RESET_CODE);
    chk("unlock_after_lockout", 32'(locked), 32'd0);

    // New code plus relock in the same cycle
    cyc(1'b0, '0, 1'b1, CODE_123456, 1'b1, 1'b0);
    enter(TB_RESET_CODE);
    enter(CODE_123456);
    chk("new_code_unlocks", 32'(locked), 32'd0);
    do_relock();

    // code_wr while locked has no effect; reset restores the factory code
    cyc(1'b0, '0, 1'b1, TB_RESET_CODE, 1'b0, 1'b0);
    enter(CODE_123456);
    do_relock();
    for (int i = 0; i < 3; i++) cyc(1'b1, TB_RESET_CODE[i*DW +: DW], 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    enter(TB_RESET_CODE);
    chk("reset_restores_code", 32'(locked), 32'd0);
    do_relock();

`ifdef CODE_LOCK_AUTO_RELOCK_EN
    // Idle timeout, restarted by a digit strobe
    enter(TB_RESET_CODE);
    idle(59);
    cyc(1'b1, 4'd7, 1'b0, '0, 1'b0, 1'b0);
    idle(70);
    chk("auto_relocked", 32'(locked), 32'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (q.size() == 0 && $urandom_range(0, 1) == 0) begin
        for (int i = 0; i < CL; i++) q.push_back(m_code[i]);
        if ($urandom_range(0, 2) == 0) q[$urandom_range(0, CL - 1)] = int'($urandom_range(0, 15));
      end
      r_dv = 1'b0;
      r_d  = DW'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        r_dv = 1'b1;
        r_d  = DW'(q.pop_front());
      end else if ($urandom_range(0, 9) == 0) begin
        r_dv = 1'b1;
      end
      r_cw  = ($urandom_range(0, 15) == 0);
      r_ci  = (CL*DW)'($urandom);
      r_rl  = ($urandom_range(0, 11) == 0);
      r_rst = ($urandom_range(0, 499) == 0);
      cyc(r_dv, r_d, r_cw, r_ci, r_rl, r_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
